// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU share arbiter:
//   - ALU_control codes (the encoding the shared ALU already understands)
//   - Arbiter FSM state encoding
//   - Requester id type (two requesters -> one bit)
// -----------------------------------------------------------------------------
package alu_pkg;

    // ALU_control codes. The arbiter never decodes these. Codes 1010-1111 are
    // forwarded unchanged, and the ALU defines what they produce.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam int REQ_ID_W = 1;
    typedef logic [REQ_ID_W-1:0] req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/arb2_rr.sv
// -----------------------------------------------------------------------------
// arb2_rr
// Two-way grant picker for the ALU share arbiter.
//   Default build            : round-robin on contention. last_grant resets to
//                              REQ1, so REQ0 wins the first contention.
//   ALU_ARB_FIXED_PRIO_EN    : REQ0 has strict priority. After STARVE_LIMIT
//                              REQ0 grants taken while REQ1 was waiting, REQ1
//                              is forced through once.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_valid0   requester 0 has an operation pending
//   i_valid1   requester 1 has an operation pending
//   i_accept   a handshake for o_grant completes at this clock edge
//   o_grant    selected requester (combinational, meaningful when any valid)
// -----------------------------------------------------------------------------
module arb2_rr
    import alu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_valid0,
    input  logic    i_valid1,
    input  logic    i_accept,
    output req_id_t o_grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_force1;

    assign w_force1 = (r_starve_cnt >= CNT_W'(STARVE_LIMIT));

    // NOTE: every output of a combinational block gets a default first, so
    // no path through it leaves a value unassigned and infers a latch.
    always_comb begin
        o_grant = REQ0;
        if (i_valid1 && (!i_valid0 || w_force1)) begin
            o_grant = REQ1;
        end
    end

    // The counter saturates at the limit. If REQ1 drops valid while it is
    // owed a turn, the turn is still owed when REQ1 returns.
    // NOTE: state registers use non-blocking assignments, so every flop in
    // the design samples the pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (i_accept) begin
            if (o_grant == REQ1) begin
                r_starve_cnt <= '0;
            end else if (i_valid1 && !w_force1) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

`else

    req_id_t r_last_grant;

    // Round-robin does not use the starvation limit. It is referenced here
    // only so that both builds share one parameter list.
    logic w_unused_starve_limit;
    assign w_unused_starve_limit = (STARVE_LIMIT > 0);

    // NOTE: every output of a combinational block gets a default first, so
    // no path through it leaves a value unassigned and infers a latch.
    always_comb begin
        o_grant = REQ0;
        if (i_valid0 && i_valid1) begin
            o_grant = ~r_last_grant;
        end else if (i_valid1) begin
            o_grant = REQ1;
        end
    end

    // Only a completed handshake moves the pointer. A requester that drops
    // valid before it is accepted leaves the fairness state unchanged.
    // NOTE: state registers use non-blocking assignments, so every flop in
    // the design samples the pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= REQ1;
        end else if (i_accept) begin
            r_last_grant <= o_grant;
        end
    end

`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Time-shares one combinational ALU between two requesters. A request
// {op, a, b} is accepted in IDLE and held in registers. The ALU is driven for
// one cycle (EXEC). The result is then held on the owner's response channel
// until that requester takes it (RESP).
// Latency: accepted at edge N, rspN_valid is high from cycle N+2. With
// rsp_ready tied high, the best case is one operation every 3 cycles.
// Optional macro ALU_ARB_FIXED_PRIO_EN selects strict REQ0 priority with a
// starvation guard instead of round-robin (see arb2_rr).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b          request channel of requester N (N=0,1)
//   alu_op, alu_a, alu_b             registered drive of the shared ALU
//   alu_result                       combinational result of the shared ALU
//   rspN_valid/ready/data            response channel of requester N
// -----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int OP_W         = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OP_W-1:0] req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OP_W-1:0] req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,

    output logic [OP_W-1:0] alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_data,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_data
);

    arb_state_t      r_state;
    arb_state_t      w_next_state;
    req_id_t         r_owner;
    req_id_t         w_grant;
    logic [OP_W-1:0] r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;
    logic            w_idle;
    logic            w_accept;

    arb2_rr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    // Ready is offered only in IDLE, and only to the granted requester that
    // is actually asking. That makes ready one-hot and a handshake identical
    // to "ready asserted".
    assign w_idle     = (r_state == ST_IDLE);
    assign req0_ready = w_idle && req0_valid && (w_grant == REQ0);
    assign req1_ready = w_idle && req1_valid && (w_grant == REQ1);
    assign w_accept   = req0_ready || req1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid = (r_owner == REQ0);
                rsp1_valid = (r_owner == REQ1);
                // The non-owner's ready is ignored. Its rsp_valid is low.
                if ((r_owner == REQ0 && rsp0_ready) ||
                    (r_owner == REQ1 && rsp1_ready)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // The operand registers drive the ALU directly. They change only on
    // acceptance, so alu_* hold their last values outside EXEC.
    // NOTE: these datapath registers are reset, not left free-running,
    // because alu_* and rsp_data are visible outputs with defined reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner  <= REQ0;
            r_op     <= OP_W'(ALU_ADD);
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_grant;
                if (w_grant == REQ0) begin
                    r_op <= req0_op;
                    r_a  <= req0_a;
                    r_b  <= req0_b;
                end else begin
                    r_op <= req1_op;
                    r_a  <= req1_a;
                    r_b  <= req1_b;
                end
            end
            if (r_state == ST_EXEC) begin
                r_result <= alu_result;
            end
        end
    end

    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign rsp0_data = r_result;
    assign rsp1_data = r_result;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters: req0 is the core execute path, req1 is the address-gen/debug path.
- Accepts {op, a, b} over valid/ready, drives the shared ALU for one cycle, then returns the result on a per-requester valid/ready response channel.
- Sits between the pipeline and the ALU; the ALU_control encoding is unchanged.

Parameters:
- XLEN, 32, operand/result width.
- OP_W, 4, ALU_control code width.
- STARVE_LIMIT, 4, consecutive req0 wins before req1 is forced (only used with ALU_ARB_FIXED_PRIO_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req0_valid  in  1  requester 0 operation valid
- req0_ready  out  1  requester 0 accepted this cycle
- req0_op  in  OP_W  ALU_control code
- req0_a  in  XLEN  operand A
- req0_b  in  XLEN  operand B
- req1_valid/req1_ready/req1_op/req1_a/req1_b  same as req0, for requester 1
- alu_op  out  OP_W  to shared ALU control
- alu_a  out  XLEN  to shared ALU operand A
- alu_b  out  XLEN  to shared ALU operand B
- alu_result  in  XLEN  shared ALU combinational result
- rsp0_valid  out  1  result ready for requester 0
- rsp0_ready  in  1  requester 0 takes result
- rsp0_data  out  XLEN  result for requester 0
- rsp1_valid/rsp1_ready/rsp1_data  same as rsp0, for requester 1

Interface decision: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: grant is computed combinationally. Only the granted requester sees ready=1, and only if its valid=1. On handshake, register op/a/b and owner id, then go to EXEC.
- EXEC: alu_op/alu_a/alu_b are driven from registers. At the clock edge, capture alu_result into the result register and go to RESP.
- RESP: rspN_valid=1 for the owner only; rsp_data holds the result. Stay in RESP until rspN_ready=1, then return to IDLE. No new request is accepted in EXEC or RESP (req*_ready=0).
- Latency: accept at edge N, rsp_valid high from cycle N+2. Best-case throughput is one op per 3 cycles with rsp_ready tied high.
- Round-robin arbitration:
  - last_grant register.
  - Both valid -> grant the one not in last_grant.
  - Only one valid -> grant that one.
  - last_grant updates only on handshake.
- alu_* outputs hold their last registered values outside EXEC. The ALU output is don't-care outside EXEC.
- Op codes are passed opaquely, including undefined codes 1010-1111. The ALU defines their result.
- Reset values:
  - state=IDLE.
  - last_grant=1, so req0 wins the first contention.
  - rsp0_valid=rsp1_valid=0.
  - rsp_data=0.
  - alu_op=4'b0000 (ADD), alu_a=alu_b=0.
  - starve count=0.
- Reset mid-operation aborts: no response is emitted and the captured request is dropped.
- A requester deasserting valid in IDLE before a handshake is legal; no grant state changes.
- rsp_ready asserted while rsp_valid=0 is ignored.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: req0 has strict priority. A starve counter increments on each req0 grant while req1_valid=1. When the counter reaches STARVE_LIMIT, req1 is granted next and the counter clears. The counter also clears on any req1 grant.
- Undefined: round-robin as above; no counter logic.

Decomposition:
- Package alu_pkg holds:
  - ALU_control localparams: ADD=0000, SUB=0001, XOR=0010, OR=0011, AND=0100, SLL=0101, SRL=0110, SRA=0111, SLT=1000, SLTU=1001.
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
  - Requester id width.
- Sub-module arb2_rr: a 2-way grant picker with last_grant state and the optional starve counter.

Test Plan:
- Single op: req0 ADD a=5 b=7 at cycle 1 with rsp0_ready=1. Expect alu_op=0000 in cycle 2, rsp0_valid with data 12 in cycle 3, and req1_ready=0 throughout.
- Contention after reset: both valid, req0 SUB 10-3, req1 XOR 0xF0^0x0F. Expect req0 granted first (rsp0_data=7), then req1 (rsp1_data=0xFF); rsp1_valid is never asserted during req0's RESP.
- Backpressure: req1 SLT a=-1 b=1 with rsp1_ready=0 for 5 cycles. Expect rsp1_valid=1 and data=1 held stable, and req0_ready=0 throughout; release ready -> IDLE next cycle.
- Reset mid-op: rst in EXEC. Expect rsp0/rsp1_valid=0, alu_op=0000, IDLE next cycle, and req0 wins the next contention.
- Round-robin fairness: both valid continuously for 6 ops. Expect grants alternating 0,1,0,1,0,1.
- With ALU_ARB_FIXED_PRIO_EN and STARVE_LIMIT=4: both valid continuously. Expect grants 0,0,0,0,1,0,0,0,0,1.
